// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared processor types: opcode constants and memory arbiter state
package processor_pkg;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LOAD  = 6'h01;
  localparam logic [5:0] OP_STORE = 6'h02;
  localparam logic [5:0] OP_CALL  = 6'h03;
  localparam logic [5:0] OP_RET   = 6'h04;
  localparam logic [5:0] OP_JUMP  = 6'h05;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOST_GRANT = 2'd1,
    HOST_ACK   = 2'd2
  } arb_state_t;

  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/memory_arbiter_wait_counter.sv
// rtl/memory_arbiter_wait_counter.sv - saturating host wait counter with synchronous clear
module arb_wait_counter #(
  parameter int MAX_COUNT = 15,
  parameter int CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_W'(MAX_COUNT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - CPU/host single-port RAM arbiter, CPU priority
// MEMORY_ARBITER_ANTI_STARVATION_EN adds a wait counter that forces a host grant.
module memory_arbiter
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE     = 18,
  parameter int WORD_SIZE     = 18,
  parameter int HOST_MAX_WAIT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic                 cpu_write_enable,
  input  logic [WORD_SIZE-1:0] cpu_data_in,
  output logic                 cpu_stall,
  output logic [WORD_SIZE-1:0] cpu_read_data,
  input  logic                 host_req,
  input  logic                 host_write,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_ack,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_write_enable,
  output logic [WORD_SIZE-1:0] mem_in,
  input  logic [WORD_SIZE-1:0] mem_out
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       w_host_wins;

`ifdef MEMORY_ARBITER_ANTI_STARVATION_EN
  localparam int CNT_W = wait_cnt_width(HOST_MAX_WAIT);

  logic [CNT_W-1:0] w_wait_cnt;
  logic             w_cnt_clear;
  logic             w_cnt_inc;

  assign w_host_wins = !cpu_req || (w_wait_cnt == CNT_W'(HOST_MAX_WAIT));
  assign w_cnt_inc   = (r_state == IDLE) && host_req && !w_host_wins;
  assign w_cnt_clear = !host_req || ((r_state == IDLE) && w_host_wins);

  arb_wait_counter #(
    .MAX_COUNT (HOST_MAX_WAIT),
    .CNT_W     (CNT_W)
  ) u_wait_counter (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_cnt_clear),
    .i_inc   (w_cnt_inc),
    .o_count (w_wait_cnt)
  );
`else
  localparam int unused_host_max_wait = HOST_MAX_WAIT;

  assign w_host_wins = !cpu_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       if (host_req && w_host_wins) w_next_state = HOST_GRANT;
      HOST_GRANT: w_next_state = HOST_ACK;
      HOST_ACK:   w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // The grant cycle itself already drives the host address so read data lands in HOST_ACK.
  always_comb begin
    mem_addr         = cpu_addr;
    mem_in           = cpu_data_in;
    mem_write_enable = cpu_req && cpu_write_enable;
    cpu_stall        = 1'b0;
    host_ack         = 1'b0;
    host_rdata       = '0;
    case (r_state)
      IDLE: begin
        if (host_req && w_host_wins) begin
          mem_addr         = host_addr;
          mem_in           = host_wdata;
          mem_write_enable = host_write;
          cpu_stall        = cpu_req;
        end
      end
      HOST_GRANT: begin
        mem_addr         = host_addr;
        mem_in           = host_wdata;
        mem_write_enable = host_write;
        cpu_stall        = cpu_req;
      end
      HOST_ACK: begin
        host_ack   = 1'b1;
        host_rdata = mem_out;
      end
      default: ;
    endcase
  end

  assign cpu_read_data = mem_out;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

  localparam int AW = 18;
  localparam int WW = 18;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_write_enable;
  logic [WW-1:0] cpu_data_in;
  logic          cpu_stall;
  logic [WW-1:0] cpu_read_data;
  logic          host_req;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [WW-1:0] host_wdata;
  logic          host_ack;
  logic [WW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_write_enable;
  logic [WW-1:0] mem_in;
  logic [WW-1:0] mem_out = '0;

  int n_checks = 0;
  int n_errors = 0;

  memory_arbiter #(
    .ADDR_SIZE     (AW),
    .WORD_SIZE     (WW),
    .HOST_MAX_WAIT (3)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_addr         (cpu_addr),
    .cpu_write_enable (cpu_write_enable),
    .cpu_data_in      (cpu_data_in),
    .cpu_stall        (cpu_stall),
    .cpu_read_data    (cpu_read_data),
    .host_req         (host_req),
    .host_write       (host_write),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_ack         (host_ack),
    .host_rdata       (host_rdata),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_in           (mem_in),
    .mem_out          (mem_out)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM model, read-before-write.
  logic [WW-1:0] ram [int];
  always @(posedge clock) begin
    logic [WW-1:0] rd;
    rd = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
    mem_out <= rd;
    if (mem_write_enable) ram[int'(mem_addr)] = mem_in;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int acks;
    int stalls;
    reset            = 1'b1;
    cpu_req          = 1'b0;
    cpu_addr         = 18'h12345;
    cpu_write_enable = 1'b0;
    cpu_data_in      = '0;
    host_req         = 1'b0;
    host_write       = 1'b0;
    host_addr        = '0;
    host_wdata       = '0;

    tick();
    tick();
    reset = 1'b0;
    #2;
    check("rst_ack", 32'(host_ack), 32'h0);
    check("rst_stall", 32'(cpu_stall), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h12345);
    check("rst_we", 32'(mem_write_enable), 32'h0);

    // Idle host write
    tick();
    host_req = 1'b1; host_write = 1'b1; host_addr = 18'h100; host_wdata = 18'h2ABCD;
    #2;
    check("hw_n_we", 32'(mem_write_enable), 32'h1);
    check("hw_n_addr", 32'(mem_addr), 32'h100);
    check("hw_n_data", 32'(mem_in), 32'h2ABCD);
    check("hw_n_ack", 32'(host_ack), 32'h0);
    tick();
    #2;
    check("hw_n1_we", 32'(mem_write_enable), 32'h1);
    check("hw_n1_ack", 32'(host_ack), 32'h0);
    tick();
    #2;
    check("hw_n2_ack", 32'(host_ack), 32'h1);
    tick();
    host_req = 1'b0; host_write = 1'b0;
    #2;
    check("hw_done_ack", 32'(host_ack), 32'h0);

    // Host readback of the same word
    tick();
    host_req = 1'b1;
    #2;
    check("hr_n_we", 32'(mem_write_enable), 32'h0);
    check("hr_n_addr", 32'(mem_addr), 32'h100);
    tick();
    tick();
    #2;
    check("hr_ack", 32'(host_ack), 32'h1);
    check("hr_rdata", 32'(host_rdata), 32'h2ABCD);
    tick();
    host_req = 1'b0;

    // CPU store at top of address space, then CPU readback
    cpu_req = 1'b1; cpu_write_enable = 1'b1; cpu_addr = 18'h3FFFF; cpu_data_in = 18'h3FFFF;
    #2;
    check("cs_we", 32'(mem_write_enable), 32'h1);
    check("cs_addr", 32'(mem_addr), 32'h3FFFF);
    check("cs_data", 32'(mem_in), 32'h3FFFF);
    check("cs_stall", 32'(cpu_stall), 32'h0);
    tick();
    cpu_write_enable = 1'b0;
    #2;
    check("cr_we", 32'(mem_write_enable), 32'h0);
    tick();
    #2;
    check("cr_data", 32'(cpu_read_data), 32'h3FFFF);

    // CPU store 0x155 at 0x200 for the host read
    cpu_write_enable = 1'b1; cpu_addr = 18'h200; cpu_data_in = 18'h155;
    tick();
    cpu_req = 1'b0; cpu_write_enable = 1'b0; cpu_addr = 18'h50;
    #2;
    check("idle_we_off", 32'(mem_write_enable), 32'h0);
    check("idle_stall_off", 32'(cpu_stall), 32'h0);

    // Host read with the CPU requesting during HOST_GRANT
    host_req = 1'b1; host_write = 1'b0; host_addr = 18'h200;
    #2;
    check("hg_n_addr", 32'(mem_addr), 32'h200);
    check("hg_n_stall", 32'(cpu_stall), 32'h0);
    tick();
    cpu_req = 1'b1;
    #2;
    check("hg_stall", 32'(cpu_stall), 32'h1);
    check("hg_addr", 32'(mem_addr), 32'h200);
    check("hg_we", 32'(mem_write_enable), 32'h0);
    tick();
    #2;
    check("hg_ack", 32'(host_ack), 32'h1);
    check("hg_rdata", 32'(host_rdata), 32'h155);
    check("hg_ack_stall", 32'(cpu_stall), 32'h0);
    check("hg_ack_addr", 32'(mem_addr), 32'h50);
    tick();
    host_req = 1'b0;
    #2;
    check("hg_after_stall", 32'(cpu_stall), 32'h0);
    check("hg_after_ack", 32'(host_ack), 32'h0);

    // Reset during HOST_GRANT aborts the access
    cpu_req = 1'b0;
    host_req = 1'b1; host_write = 1'b1; host_addr = 18'h300; host_wdata = 18'h111;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; host_req = 1'b0;
    #2;
    check("ra_ack", 32'(host_ack), 32'h0);
    check("ra_we", 32'(mem_write_enable), 32'h0);
    tick();
    #2;
    check("ra_ack2", 32'(host_ack), 32'h0);
    host_req = 1'b1;
    #1;
    check("ra_rereq_we", 32'(mem_write_enable), 32'h1);
    tick();
    tick();
    #2;
    check("ra_rereq_ack", 32'(host_ack), 32'h1);
    tick();
    host_req = 1'b0; host_write = 1'b0;

    // Continuous contention
    cpu_req = 1'b1; cpu_addr = 18'h10;
    host_req = 1'b1; host_addr = 18'h100;
`ifdef MEMORY_ARBITER_ANTI_STARVATION_EN
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("sv_block%0d_stall", i), 32'(cpu_stall), 32'h0);
      check($sformatf("sv_block%0d_addr", i), 32'(mem_addr), 32'h10);
      tick();
    end
    #2;
    check("sv_grant_stall", 32'(cpu_stall), 32'h1);
    check("sv_grant_addr", 32'(mem_addr), 32'h100);
    tick();
    #2;
    check("sv_hg_stall", 32'(cpu_stall), 32'h1);
    check("sv_hg_ack", 32'(host_ack), 32'h0);
    tick();
    #2;
    check("sv_ack", 32'(host_ack), 32'h1);
    check("sv_rdata", 32'(host_rdata), 32'h2ABCD);
    check("sv_ack_stall", 32'(cpu_stall), 32'h0);
    tick();
    host_req = 1'b0;
`else
    acks = 0;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (host_ack) acks++;
      if (cpu_stall) stalls++;
      tick();
    end
    check("sv_no_ack", 32'(acks), 32'h0);
    check("sv_no_stall", 32'(stalls), 32'h0);
    cpu_req = 1'b0;
    #2;
    check("sv_release_addr", 32'(mem_addr), 32'h100);
    tick();
    tick();
    #2;
    check("sv_release_ack", 32'(host_ack), 32'h1);
    check("sv_release_rdata", 32'(host_rdata), 32'h2ABCD);
    tick();
    host_req = 1'b0;
`endif
    #2;
    check("end_ack", 32'(host_ack), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 18, memory address width.
REQ-002 Parameter WORD_SIZE, default 18, memory data width.
REQ-003 Parameter HOST_MAX_WAIT, default 15, max cycles the host may be blocked by the CPU (anti-starvation build only).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  stage-2 memory access this cycle (load, store, call push).
REQ-007 cpu_addr / cpu_write_enable / cpu_data_in  input  ADDR_SIZE / 1 / WORD_SIZE  stage-2 memory address, write strobe and write data.
REQ-008 cpu_stall  output  1  CPU access not performed this cycle; pipeline must hold.
REQ-009 cpu_read_data  output  WORD_SIZE  mem_out passed through to the CPU.
REQ-010 host_req / host_write / host_addr / host_wdata  input  1 / 1 / ADDR_SIZE / WORD_SIZE  host (debug/loader) request, held stable until host_ack.
REQ-011 host_ack  output  1  one-cycle pulse: host access complete.
REQ-012 host_rdata  output  WORD_SIZE  read data, valid while host_ack=1.
REQ-013 mem_addr / mem_write_enable / mem_in  output  ADDR_SIZE / 1 / WORD_SIZE  single-port synchronous RAM port.
REQ-014 mem_out  input  WORD_SIZE  RAM read data, valid one cycle after mem_addr.

Function
REQ-015 FSM states: IDLE, HOST_GRANT, HOST_ACK.
REQ-016 IDLE: RAM port driven by the CPU inputs; mem_write_enable = cpu_req && cpu_write_enable.
REQ-017 IDLE -> HOST_GRANT when host_req=1 and host wins (REQ-018); the RAM port is driven by the host in that same cycle and cpu_stall = cpu_req.
REQ-018 Host wins in IDLE when cpu_req=0, or (anti-starvation build) when wait_cnt = HOST_MAX_WAIT.
REQ-019 HOST_GRANT: RAM port driven by the host; mem_write_enable = host_write; cpu_stall = cpu_req; unconditional transition to HOST_ACK.
REQ-020 HOST_ACK: host_ack=1, host_rdata=mem_out; RAM port returned to the CPU (cpu_stall=0); unconditional transition to IDLE.
REQ-021 Host latency: request granted in cycle N is acknowledged in cycle N+2; the host is never granted twice without passing through IDLE.
REQ-022 The host deasserts host_req in the cycle after host_ack; host_req sampled in HOST_ACK is ignored.
REQ-023 cpu_stall is combinational and is 0 whenever cpu_req=0.
REQ-024 wait_cnt: increments (saturating at HOST_MAX_WAIT) each IDLE cycle with host_req=1 and the host losing; clears on entry to HOST_GRANT or when host_req=0.
REQ-025 Outputs never carry X while reset=0; mem_write_enable=0 whenever no requester owns a write.

Reset
REQ-026 Reset forces state IDLE, wait_cnt=0 and host_ack=0 on the next edge; reset wins over every transition.
REQ-027 Reset during HOST_GRANT aborts the access with no host_ack; the host re-requests.

Configuration
REQ-028 Macro MEMORY_ARBITER_ANTI_STARVATION_EN defined: wait_cnt and the REQ-018 forced grant are compiled in.
REQ-029 Macro undefined: no counter, HOST_MAX_WAIT unused; the host wins only when cpu_req=0, so the CPU has strict priority and the host may starve.

Structure
REQ-030 Shared package processor_pkg holds the enum arb_state_t {IDLE, HOST_GRANT, HOST_ACK} next to the existing OP_* opcode constants.
REQ-031 One sub-module, arb_wait_counter (saturating counter with clear), is instantiated only in the anti-starvation build.

Verification
REQ-032 Reset: reset=1 for 2 cycles -> host_ack=0, cpu_stall=0, CPU address drives mem_addr.
REQ-033 Idle host write: cpu_req=0, host_req=1, host_addr=0x100, host_wdata=0x2ABCD -> mem_write_enable=1 at 0x100 in N, host_ack=1 in N+2, readback 0x2ABCD.
REQ-034 Host read during HOST_GRANT with cpu_req=1: mem_out returns 0x155 -> host_rdata=0x155 with host_ack; cpu_stall=1 only in the HOST_GRANT cycle (and the grant cycle N).
REQ-035 Starvation (macro on, HOST_MAX_WAIT=3): cpu_req=1 and host_req=1 continuously -> grant after 3 blocked cycles, host_ack 2 cycles later; macro off -> no host_ack for 100 cycles.
REQ-036 Reset asserted in HOST_GRANT -> no host_ack, state IDLE, host re-request then completes normally.
REQ-037 CPU store with cpu_req=1, cpu_addr=0x3FFFF, data 0x3FFFF and no host request -> mem_write_enable=1 at 0x3FFFF, cpu_stall=0.
